// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection.
// It captures decoder controls and operands from ID, resolves the destination
// register, and inserts a bubble on a load-use hazard or a flush. A freeze
// input holds the whole register.
module id_ex_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [1:0]       id_RegDst,
    input  logic [1:0]       id_ToReg,
    input  logic [1:0]       id_ALUSrc,
    input  logic             id_RFWr,
    input  logic             id_ALUSrc0,
    input  logic [4:0]       id_ALUOp,
    input  logic [1:0]       id_DMWr,
    input  logic [2:0]       id_DMRe,
    input  logic [31:0]      id_pc4,
    input  logic [31:0]      id_rd1,
    input  logic [31:0]      id_rd2,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_shamt,
    output logic             ex_valid,
    output logic [1:0]       ex_RegDst,
    output logic [1:0]       ex_ToReg,
    output logic [1:0]       ex_ALUSrc,
    output logic             ex_RFWr,
    output logic             ex_ALUSrc0,
    output logic [4:0]       ex_ALUOp,
    output logic [1:0]       ex_DMWr,
    output logic [2:0]       ex_DMRe,
    output logic [31:0]      ex_pc4,
    output logic [31:0]      ex_rd1,
    output logic [31:0]      ex_rd2,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_shamt,
    output logic [4:0]       ex_wreg,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Decoder encodings shared with the control unit.
    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;
    localparam logic [1:0] DMWR_NOP = 2'b00;
    localparam logic [2:0] DMRE_NOP = 3'b000;
    localparam logic [4:0] ALU_NOP  = 5'b00000;

    typedef struct packed {
        logic        valid;
        logic [1:0]  reg_dst;
        logic [1:0]  to_reg;
        logic [1:0]  alu_src;
        logic        rf_wr;
        logic        alu_src0;
        logic [4:0]  alu_op;
        logic [1:0]  dm_wr;
        logic [2:0]  dm_re;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [4:0]  wreg;
    } ex_t;

    // Bubble: no side effects, data fields cleared so the stage is deterministic.
    function automatic ex_t bubble();
        ex_t b;
        b        = '0;
        b.dm_wr  = DMWR_NOP;
        b.dm_re  = DMRE_NOP;
        b.alu_op = ALU_NOP;
        return b;
    endfunction

    ex_t              ex_d, ex_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [4:0]       wreg_res;

    // Resolve the destination register from the RegDst selector.
    always_comb begin
        unique case (id_RegDst)
            RD_RT:   wreg_res = id_rt;
            RD_RD:   wreg_res = id_rd;
            RD_RA:   wreg_res = 5'd31;
            default: wreg_res = 5'd0;
        endcase
    end

    // Load-use hazard: a load in EX writes a register that ID reads (rt compared conservatively).
    always_comb begin
        stall = ex_q.valid && ex_q.rf_wr && (ex_q.dm_re != DMRE_NOP) && (ex_q.wreg != 5'd0)
                && id_valid && ((ex_q.wreg == id_rs) || (ex_q.wreg == id_rt));
    end

    // Next-state: hold > flush > stall > capture.
    always_comb begin
        // NOTE: defaults first so every path assigns ex_d/cnt_d and no latch is inferred.
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (hold) begin
            ex_d  = ex_q;
        end else if (flush) begin
            ex_d  = bubble();
        end else if (stall) begin
            ex_d  = bubble();
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            ex_d.valid    = id_valid;
            ex_d.reg_dst  = id_RegDst;
            ex_d.to_reg   = id_ToReg;
            ex_d.alu_src  = id_ALUSrc;
            ex_d.rf_wr    = id_valid ? id_RFWr : 1'b0;
            ex_d.alu_src0 = id_ALUSrc0;
            ex_d.alu_op   = id_ALUOp;
            ex_d.dm_wr    = id_valid ? id_DMWr : DMWR_NOP;
            ex_d.dm_re    = id_valid ? id_DMRe : DMRE_NOP;
            ex_d.pc4      = id_pc4;
            ex_d.rd1      = id_rd1;
            ex_d.rd2      = id_rd2;
            ex_d.imm      = id_imm;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.rd       = id_rd;
            ex_d.shamt    = id_shamt;
            ex_d.wreg     = wreg_res;
        end
    end

    // State register; reset loads a bubble without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
        if (rst) begin
            ex_q  <= bubble();
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    // Output mapping.
    always_comb begin
        ex_valid   = ex_q.valid;
        ex_RegDst  = ex_q.reg_dst;
        ex_ToReg   = ex_q.to_reg;
        ex_ALUSrc  = ex_q.alu_src;
        ex_RFWr    = ex_q.rf_wr;
        ex_ALUSrc0 = ex_q.alu_src0;
        ex_ALUOp   = ex_q.alu_op;
        ex_DMWr    = ex_q.dm_wr;
        ex_DMRe    = ex_q.dm_re;
        ex_pc4     = ex_q.pc4;
        ex_rd1     = ex_q.rd1;
        ex_rd2     = ex_q.rd2;
        ex_imm     = ex_q.imm;
        ex_rs      = ex_q.rs;
        ex_rt      = ex_q.rt;
        ex_rd      = ex_q.rd;
        ex_shamt   = ex_q.shamt;
        ex_wreg    = ex_q.wreg;
        bubble_cnt = cnt_q;
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: capture, destination resolution, load-use
// bubbles, hold/flush priority, async reset and counter saturation (CNT_W=4).
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst, hold, flush, id_valid;
    logic [1:0]  id_RegDst, id_ToReg, id_ALUSrc, id_DMWr;
    logic        id_RFWr, id_ALUSrc0;
    logic [4:0]  id_ALUOp, id_rs, id_rt, id_rd, id_shamt;
    logic [2:0]  id_DMRe;
    logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;

    logic        ex_valid, ex_RFWr, ex_ALUSrc0, stall;
    logic [1:0]  ex_RegDst, ex_ToReg, ex_ALUSrc, ex_DMWr;
    logic [4:0]  ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_shamt, ex_wreg;
    logic [2:0]  ex_DMRe;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_RFWr, s_ALUSrc0, s_stall;
    logic [1:0]  s_RegDst, s_ToReg, s_ALUSrc, s_DMWr;
    logic [4:0]  s_ALUOp, s_rs, s_rt, s_rd, s_shamt, s_wreg;
    logic [2:0]  s_DMRe;
    logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
    logic [3:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
    localparam logic [2:0] DMRE_LW = 3'b001;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_ToReg(id_ToReg), .id_ALUSrc(id_ALUSrc),
        .id_RFWr(id_RFWr), .id_ALUSrc0(id_ALUSrc0), .id_ALUOp(id_ALUOp),
        .id_DMWr(id_DMWr), .id_DMRe(id_DMRe), .id_pc4(id_pc4), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_shamt(id_shamt),
        .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_ToReg(ex_ToReg),
        .ex_ALUSrc(ex_ALUSrc), .ex_RFWr(ex_RFWr), .ex_ALUSrc0(ex_ALUSrc0),
        .ex_ALUOp(ex_ALUOp), .ex_DMWr(ex_DMWr), .ex_DMRe(ex_DMRe),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_wreg(ex_wreg), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_ToReg(id_ToReg), .id_ALUSrc(id_ALUSrc),
        .id_RFWr(id_RFWr), .id_ALUSrc0(id_ALUSrc0), .id_ALUOp(id_ALUOp),
        .id_DMWr(id_DMWr), .id_DMRe(id_DMRe), .id_pc4(id_pc4), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_shamt(id_shamt),
        .ex_valid(s_valid), .ex_RegDst(s_RegDst), .ex_ToReg(s_ToReg),
        .ex_ALUSrc(s_ALUSrc), .ex_RFWr(s_RFWr), .ex_ALUSrc0(s_ALUSrc0),
        .ex_ALUOp(s_ALUOp), .ex_DMWr(s_DMWr), .ex_DMRe(s_DMRe),
        .ex_pc4(s_pc4), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_shamt(s_shamt),
        .ex_wreg(s_wreg), .stall(s_stall), .bubble_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one ID-stage instruction; data fields are tagged by 'base'.
    task automatic set_id(input logic v, input logic [1:0] regdst, input logic rfwr,
                          input logic [1:0] dmwr, input logic [2:0] dmre,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] base);
        id_valid   = v;
        id_RegDst  = regdst;
        id_RFWr    = rfwr;
        id_DMWr    = dmwr;
        id_DMRe    = dmre;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_ToReg   = 2'b01;
        id_ALUSrc  = 2'b01;
        id_ALUSrc0 = 1'b1;
        id_ALUOp   = 5'd2;
        id_shamt   = 5'd3;
        id_pc4     = base + 32'd4;
        id_rd1     = base + 32'h11;
        id_rd2     = base + 32'h22;
        id_imm     = base + 32'h33;
    endtask

    task automatic set_lw(input logic [4:0] rt, input logic [31:0] base);
        set_id(1'b1, RD_RT, 1'b1, 2'b00, DMRE_LW, 5'd29, rt, 5'd0, base);
    endtask

    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] base);
        set_id(1'b1, RD_RD, 1'b1, 2'b00, 3'b000, rs, rt, rd, base);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        set_id(1'b0, RD_RT, 1'b0, 2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
        #2;
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_cnt",   32'(bubble_cnt), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_dmre",  32'(ex_DMRe), 0);
        @(negedge clk);
        rst = 1'b0;

        // Load-use: LW $8 then ADD rs=8 -> one bubble.
        set_lw(5'd8, 32'h100);
        step();
        check("lw_valid", 32'(ex_valid), 1);
        check("lw_wreg",  32'(ex_wreg), 8);
        check("lw_pc4",   ex_pc4, 32'h104);
        check("lw_dmre",  32'(ex_DMRe), 1);
        check("lw_toreg", 32'(ex_ToReg), 1);
        check("lw_aluop", 32'(ex_ALUOp), 2);
        check("lw_shamt", 32'(ex_shamt), 3);
        set_add(5'd8, 5'd9, 5'd10, 32'h200);
        #1;
        check("lu_stall", 32'(stall), 1);
        step();
        check("lu_bub_valid", 32'(ex_valid), 0);
        check("lu_bub_rfwr",  32'(ex_RFWr), 0);
        check("lu_bub_dmre",  32'(ex_DMRe), 0);
        check("lu_bub_rd1",   ex_rd1, 0);
        check("lu_bub_src0",  32'(ex_ALUSrc0), 0);
        check("lu_cnt",       32'(bubble_cnt), 1);
        check("lu_stall_off", 32'(stall), 0);
        step();
        check("lu_add_valid", 32'(ex_valid), 1);
        check("lu_add_wreg",  32'(ex_wreg), 10);
        check("lu_add_rd1",   ex_rd1, 32'h211);
        check("lu_add_imm",   ex_imm, 32'h233);
        check("lu_add_rs",    32'(ex_rs), 8);

        // LW to $0: never a hazard.
        set_lw(5'd0, 32'h300);
        step();
        set_add(5'd0, 5'd0, 5'd4, 32'h400);
        #1;
        check("r0_stall", 32'(stall), 0);
        step();
        check("r0_valid", 32'(ex_valid), 1);
        check("r0_wreg",  32'(ex_wreg), 4);
        check("r0_cnt",   32'(bubble_cnt), 1);

        // Destination resolution: JAL -> 31, RD -> rd, undefined code -> 0.
        set_id(1'b1, RD_RA, 1'b1, 2'b00, 3'b000, 5'd1, 5'd2, 5'd3, 32'h500);
        step();
        check("jal_wreg", 32'(ex_wreg), 31);
        set_add(5'd1, 5'd2, 5'd12, 32'h600);
        step();
        check("add_wreg12", 32'(ex_wreg), 12);
        set_id(1'b1, 2'b11, 1'b1, 2'b00, 3'b000, 5'd1, 5'd2, 5'd3, 32'h700);
        step();
        check("rd11_wreg", 32'(ex_wreg), 0);

        // Invalid ID instruction: side-effect controls forced off.
        set_id(1'b0, RD_RT, 1'b1, 2'b10, DMRE_LW, 5'd1, 5'd2, 5'd3, 32'h800);
        step();
        check("inv_valid", 32'(ex_valid), 0);
        check("inv_rfwr",  32'(ex_RFWr), 0);
        check("inv_dmwr",  32'(ex_DMWr), 0);
        check("inv_dmre",  32'(ex_DMRe), 0);
        check("inv_pc4",   ex_pc4, 32'h804);

        // Hazard under hold: frozen 3 cycles, then one bubble.
        set_lw(5'd5, 32'h900);
        step();
        set_add(5'd5, 5'd6, 5'd7, 32'hA00);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_stall", 32'(stall), 1);
            check("hold_valid", 32'(ex_valid), 1);
            check("hold_wreg",  32'(ex_wreg), 5);
            check("hold_pc4",   ex_pc4, 32'h904);
            check("hold_cnt",   32'(bubble_cnt), 1);
        end
        hold = 1'b0;
        step();
        check("hold_bub_valid", 32'(ex_valid), 0);
        check("hold_bub_cnt",   32'(bubble_cnt), 2);
        step();
        check("hold_add_wreg",  32'(ex_wreg), 7);

        // Stall and flush on the same edge: bubble, no count.
        set_lw(5'd7, 32'hB00);
        step();
        set_add(5'd1, 5'd7, 5'd2, 32'hC00);
        flush = 1'b1;
        #1;
        check("fl_stall", 32'(stall), 1);
        step();
        check("fl_valid", 32'(ex_valid), 0);
        check("fl_rfwr",  32'(ex_RFWr), 0);
        check("fl_cnt",   32'(bubble_cnt), 2);
        flush = 1'b0;
        step();
        check("fl_next_valid", 32'(ex_valid), 1);

        // Asynchronous reset pulse between edges.
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(ex_valid), 0);
        check("arst_cnt",   32'(bubble_cnt), 0);
        check("arst_wreg",  32'(ex_wreg), 0);
        rst = 1'b0;
        step();
        check("arst_resume", 32'(ex_valid), 1);

        // Saturation: 16 load-use pairs from a clean count.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_lw(5'd3, 32'hD00);
            step();
            set_add(5'd3, 5'd4, 5'd5, 32'hE00);
            step();
            step();
        end
        check("sat_cnt16", 32'(bubble_cnt), 16);
        check("sat_cnt4",  32'(s_cnt), 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the load-use bubble counter.
REQ-002 SHALL have clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have hold  input  1: global freeze (memory wait); ID/EX contents held.
REQ-005 SHALL have flush  input  1: discard ID-stage instruction; insert bubble.
REQ-006 SHALL have id_valid  input  1: ID stage holds a real instruction.
REQ-007 SHALL have id_RegDst, id_ToReg, id_ALUSrc  input  2 each: decoder controls.
REQ-008 SHALL have id_RFWr, id_ALUSrc0  input  1 each; id_ALUOp input 5; id_DMWr input 2; id_DMRe input 3.
REQ-009 SHALL have id_pc4, id_rd1, id_rd2, id_imm  input  32 each: PC+4, rs data, rt data, extended immediate.
REQ-010 SHALL have id_rs, id_rt, id_rd, id_shamt  input  5 each: instruction fields.
REQ-011 SHALL have ex_* outputs  output  (same widths): registered copies of every id_* input above, plus ex_valid 1 and ex_wreg 5 (resolved destination).
REQ-012 SHALL have stall  output  1: combinational; freezes PC and IF/ID register.
REQ-013 SHALL have bubble_cnt  output  CNT_W: count of load-use bubbles inserted.

Function
REQ-014 SHALL compute ex_wreg at capture: `RD_RT -> id_rt, `RD_RD -> id_rd, `RD_RA -> 5'd31 (encodings from ctrl_encode_def.v); other codes -> 5'd0.
REQ-015 SHALL assert stall = ex_valid & ex_RFWr & (ex_DMRe != `DMRE_NOP) & (ex_wreg != 0) & id_valid & (ex_wreg == id_rs | ex_wreg == id_rt); conservative (rt compared even when unused).
REQ-016 SHALL define bubble: ex_valid=0, ex_RFWr=0, ex_DMWr=`DMWR_NOP, ex_DMRe=`DMRE_NOP, ex_ALUOp=`ALU_NOP, ex_ALUSrc0=0, ex_wreg=0; data fields don't-care but SHALL be cleared to 0.
REQ-017 SHALL apply per-edge priority: hold > flush > stall > normal capture.
REQ-018 hold=1: all ex_* and bubble_cnt unchanged; stall still driven combinationally.
REQ-019 flush=1 (hold=0): load bubble regardless of stall; bubble_cnt unchanged.
REQ-020 stall=1 (hold=0, flush=0): load bubble; bubble_cnt += 1, saturating at all-ones.
REQ-021 otherwise: capture all id_* fields, ex_valid <= id_valid, ex_wreg per REQ-014; latency ID->EX exactly 1 cycle.
REQ-022 id_valid=0 on capture SHALL force ex_RFWr=0, ex_DMWr=`DMWR_NOP, ex_DMRe=`DMRE_NOP.
REQ-023 stall SHALL deassert the cycle after the bubble is loaded (bubble has ex_valid=0); a load-use costs exactly 1 bubble.
REQ-024 stall with hold=1 SHALL persist without inserting bubbles or counting until hold drops.

Reset
REQ-025 rst=1 SHALL immediately (no clock) load bubble state into all ex_* outputs and clear bubble_cnt to 0.
REQ-026 rst deasserted mid-operation SHALL resume capture on the first rising edge with rst=0; stall=0 out of reset.

Verification
REQ-027 LW $t0(rt=8) captured, next ID ADD rs=8 rt=9 -> stall=1 one cycle, EX gets bubble, bubble_cnt=1, ADD enters EX next cycle.
REQ-028 LW with rt=0 followed by user of $0 -> stall=0, no bubble, bubble_cnt=0.
REQ-029 JAL (RegDst=`RD_RA, RFWr=1) captured -> ex_wreg=31; ADD with RegDst=`RD_RD rd=12 -> ex_wreg=12.
REQ-030 load-use hazard with hold=1 for 3 cycles -> ex_* unchanged, stall=1 throughout, bubble_cnt unchanged; hold drops -> one bubble, count +1.
REQ-031 stall and flush same edge -> bubble, bubble_cnt unchanged; rst pulse between edges -> ex_valid=0, bubble_cnt=0 asynchronously.
REQ-032 CNT_W=4, 16 consecutive load-use pairs -> bubble_cnt saturates at 15.
